// File: rtl/btb_pkg.sv
// Shared definitions for the set-associative branch target buffer:
// width-derivation helpers, counter init value and the flush FSM states.
package btb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } fsm_state_e;

  localparam int CTR_WIDTH_DEFAULT = 2;
  localparam logic [CTR_WIDTH_DEFAULT-1:0] CTR_WEAK_TAKEN = 2'b10;

  function automatic int set_bits(input int sets);
    return $clog2(sets);
  endfunction

  // A single-way BTB still carries a 1-bit way index.
  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic int tag_width(input int pc_width, input int idx_lsb, input int sets);
    return pc_width - idx_lsb - $clog2(sets);
  endfunction

  // Weakly-taken pattern for an arbitrary counter width: MSB set, rest clear.
  function automatic logic [31:0] ctr_weak_taken(input int ctr_width);
    return 32'd1 << (ctr_width - 1);
  endfunction

endpackage

// File: rtl/btb_assoc_sat_counter_upd.sv
// Next value of a saturating direction counter; never wraps in either direction.
module sat_counter_upd #(
  parameter int CTR_WIDTH = 2
) (
  input  logic [CTR_WIDTH-1:0] ctr,
  input  logic                 taken,
  output logic [CTR_WIDTH-1:0] ctr_next
);

  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_ONE = CTR_WIDTH'(1);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) ctr_next = ctr + CTR_ONE;
    end else begin
      if (ctr != '0) ctr_next = ctr - CTR_ONE;
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB: combinational lookup on the fetch PC, registered
// resolve-stage update with per-set round-robin victims, multi-cycle flush.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int SETS      = 8,
  parameter int WAYS      = 2,
  parameter int CTR_WIDTH = 2,
  parameter int IDX_LSB   = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [PC_WIDTH-1:0]                pc_current,
  output logic                               pred_hit,
  output logic                               pred_taken,
  output logic [PC_WIDTH-1:0]                pred_target,
  output logic [btb_pkg::way_bits(WAYS)-1:0] pred_way,
  input  logic                               upd_valid,
  input  logic [PC_WIDTH-1:0]                upd_pc,
  input  logic [PC_WIDTH-1:0]                upd_target,
  input  logic                               upd_taken,
  input  logic                               flush_req,
  output logic                               busy
);

  localparam int SET_BITS  = set_bits(SETS);
  localparam int WAY_BITS  = way_bits(WAYS);
  localparam int TAG_WIDTH = tag_width(PC_WIDTH, IDX_LSB, SETS);
  localparam int TAG_LSB   = IDX_LSB + SET_BITS;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(ctr_weak_taken(CTR_WIDTH));
  localparam logic [WAY_BITS-1:0]  LAST_WAY = WAY_BITS'(WAYS - 1);
  localparam logic [SET_BITS-1:0]  LAST_SET = SET_BITS'(SETS - 1);

  fsm_state_e           state_reg;
  logic [SET_BITS-1:0]  flush_cnt_reg;
  logic [WAYS-1:0]      valid_reg  [SETS];
  logic [CTR_WIDTH-1:0] ctr_reg    [SETS][WAYS];
  logic [WAY_BITS-1:0]  victim_reg [SETS];
  logic [TAG_WIDTH-1:0] tag_mem    [SETS][WAYS];
  logic [PC_WIDTH-1:0]  target_mem [SETS][WAYS];

  logic [SET_BITS-1:0]  look_set;
  logic [TAG_WIDTH-1:0] look_tag;
  logic [WAYS-1:0]      look_match;
  logic                 look_hit;
  logic [WAY_BITS-1:0]  look_way;

  logic [SET_BITS-1:0]  upd_set;
  logic [TAG_WIDTH-1:0] upd_tag;
  logic [WAYS-1:0]      upd_match;
  logic                 upd_hit;
  logic [WAY_BITS-1:0]  upd_hit_way;
  logic                 free_any;
  logic [WAY_BITS-1:0]  free_way;
  logic [WAY_BITS-1:0]  alloc_way;
  logic [WAY_BITS-1:0]  victim_next;
  logic [CTR_WIDTH-1:0] ctr_sel;
  logic [CTR_WIDTH-1:0] ctr_upd;
  logic                 upd_en;
  logic                 do_hit;
  logic                 do_alloc;

  assign look_set = pc_current[TAG_LSB-1:IDX_LSB];
  assign look_tag = pc_current[PC_WIDTH-1:TAG_LSB];
  assign upd_set  = upd_pc[TAG_LSB-1:IDX_LSB];
  assign upd_tag  = upd_pc[PC_WIDTH-1:TAG_LSB];

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way_cmp
      assign look_match[gi] = valid_reg[look_set][gi] && (tag_mem[look_set][gi] == look_tag);
      assign upd_match[gi]  = valid_reg[upd_set][gi]  && (tag_mem[upd_set][gi]  == upd_tag);
    end
  endgenerate

  // Descending scans so the lowest matching / free way is the one that sticks.
  always_comb begin
    look_hit    = 1'b0;
    look_way    = '0;
    upd_hit     = 1'b0;
    upd_hit_way = '0;
    free_any    = 1'b0;
    free_way    = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (look_match[w]) begin
        look_hit = 1'b1;
        look_way = WAY_BITS'(w);
      end
      if (upd_match[w]) begin
        upd_hit     = 1'b1;
        upd_hit_way = WAY_BITS'(w);
      end
      if (!valid_reg[upd_set][w]) begin
        free_any = 1'b1;
        free_way = WAY_BITS'(w);
      end
    end
  end

  assign busy        = (state_reg == FLUSH);
  assign pred_hit    = look_hit && !busy;
  assign pred_taken  = pred_hit ? ctr_reg[look_set][look_way][CTR_WIDTH-1] : 1'b0;
  assign pred_target = pred_hit ? target_mem[look_set][look_way] : '0;
  assign pred_way    = pred_hit ? look_way : '0;

  assign alloc_way   = free_any ? free_way : victim_reg[upd_set];
  assign victim_next = (victim_reg[upd_set] == LAST_WAY) ? '0 : victim_reg[upd_set] + WAY_BITS'(1);
  assign ctr_sel     = ctr_reg[upd_set][upd_hit_way];

  // A flush request wins over an update presented in the same cycle.
  assign upd_en   = (state_reg == IDLE) && !flush_req && upd_valid;
  assign do_hit   = upd_en && upd_hit;
  assign do_alloc = upd_en && !upd_hit && upd_taken;

  sat_counter_upd #(
    .CTR_WIDTH(CTR_WIDTH)
  ) u_ctr_upd (
    .ctr     (ctr_sel),
    .taken   (upd_taken),
    .ctr_next(ctr_upd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      flush_cnt_reg <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s]  <= '0;
        victim_reg[s] <= '0;
        for (int w = 0; w < WAYS; w++) ctr_reg[s][w] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (flush_req) begin
            state_reg     <= FLUSH;
            flush_cnt_reg <= '0;
          end else if (do_hit) begin
            ctr_reg[upd_set][upd_hit_way] <= ctr_upd;
          end else if (do_alloc) begin
            valid_reg[upd_set][alloc_way] <= 1'b1;
            ctr_reg[upd_set][alloc_way]   <= CTR_INIT;
            if (!free_any) victim_reg[upd_set] <= victim_next;
          end
        end
        FLUSH: begin
          valid_reg[flush_cnt_reg]  <= '0;
          victim_reg[flush_cnt_reg] <= '0;
          flush_cnt_reg             <= flush_cnt_reg + SET_BITS'(1);
          if (flush_cnt_reg == LAST_SET) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Tag/target payload carries no reset; validity lives in valid_reg.
  always_ff @(posedge clk) begin
    if (do_hit && upd_taken) begin
      target_mem[upd_set][upd_hit_way] <= upd_target;
    end
    if (do_alloc) begin
      tag_mem[upd_set][alloc_way]    <= upd_tag;
      target_mem[upd_set][alloc_way] <= upd_target;
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Scoreboard bench for btb_assoc: a driver pushes reference-model predictions,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_btb_assoc;

  localparam int PCW  = 32;
  localparam int SETS = 8;
  localparam int WAYS = 2;
  localparam int CTRW = 2;
  localparam int IDX  = 2;
  localparam int CTR_MAX   = (1 << CTRW) - 1;
  localparam int CTR_HALF  = 1 << (CTRW - 1);

  logic            clk;
  logic            rst_n;
  logic [PCW-1:0]  pc_current;
  logic            pred_hit;
  logic            pred_taken;
  logic [PCW-1:0]  pred_target;
  logic [0:0]      pred_way;
  logic            upd_valid;
  logic [PCW-1:0]  upd_pc;
  logic [PCW-1:0]  upd_target;
  logic            upd_taken;
  logic            flush_req;
  logic            busy;

  btb_assoc #(
    .PC_WIDTH(PCW), .SETS(SETS), .WAYS(WAYS), .CTR_WIDTH(CTRW), .IDX_LSB(IDX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_current (pc_current),
    .pred_hit   (pred_hit),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .pred_way   (pred_way),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken),
    .flush_req  (flush_req),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        hit;
    logic        taken;
    logic [31:0] target;
    int          way;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   n_tx     = 0;

  // Reference model: each set holds WAYS entries keyed by the PC's line number.
  bit          m_valid [SETS][WAYS];
  int unsigned m_tag   [SETS][WAYS];
  logic [31:0] m_target[SETS][WAYS];
  int          m_ctr   [SETS][WAYS];
  int          m_victim[SETS];
  int          flush_left;

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_victim[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_ctr[s][w]   = 0;
      end
    end
    flush_left = 0;
  endfunction

  function automatic exp_t model_lookup(input logic [31:0] pc);
    exp_t        e;
    int unsigned line = pc >> IDX;
    int unsigned set  = line % SETS;
    int unsigned tag  = line / SETS;
    e.pc = pc; e.hit = 0; e.taken = 0; e.target = 0; e.way = 0;
    e.busy = (flush_left > 0);
    if (!e.busy) begin
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (m_valid[set][w] && m_tag[set][w] == tag) begin
          e.hit = 1; e.way = w;
          e.taken = (m_ctr[set][w] >= CTR_HALF);
          e.target = m_target[set][w];
        end
      end
    end
    return e;
  endfunction

  function automatic void model_step(input bit uv, input logic [31:0] upc,
                                     input logic [31:0] utgt, input bit utk, input bit fl);
    int unsigned line = upc >> IDX;
    int unsigned set  = line % SETS;
    int unsigned tag  = line / SETS;
    int          hw   = -1;
    int          fw   = -1;
    if (flush_left > 0) begin
      flush_left--;
    end else if (fl) begin
      for (int s = 0; s < SETS; s++) begin
        m_victim[s] = 0;
        for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      end
      flush_left = SETS;
    end else if (uv) begin
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (m_valid[set][w] && m_tag[set][w] == tag) hw = w;
        if (!m_valid[set][w]) fw = w;
      end
      if (hw >= 0) begin
        if (utk) begin
          if (m_ctr[set][hw] < CTR_MAX) m_ctr[set][hw]++;
          m_target[set][hw] = utgt;
        end else if (m_ctr[set][hw] > 0) begin
          m_ctr[set][hw]--;
        end
      end else if (utk) begin
        if (fw < 0) begin
          fw = m_victim[set];
          m_victim[set] = (m_victim[set] + 1) % WAYS;
        end
        m_valid[set][fw]  = 1'b1;
        m_tag[set][fw]    = tag;
        m_target[set][fw] = utgt;
        m_ctr[set][fw]    = CTR_HALF;
      end
    end
  endfunction

  task automatic cycle(input logic [31:0] pc, input bit uv, input logic [31:0] upc,
                       input logic [31:0] utgt, input bit utk, input bit fl);
    exp_t e;
    @(posedge clk);
    #1;
    pc_current = pc; upd_valid = uv; upd_pc = upc; upd_target = utgt;
    upd_taken = utk; flush_req = fl;
    e = model_lookup(pc);
    e.id = n_tx++;
    sb_q.push_back(e);
    model_step(uv, upc, utgt, utk, fl);
  endtask

  task automatic look(input logic [31:0] pc);
    cycle(pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
    cycle(pc, 1'b1, pc, tgt, tk, 1'b0);
  endtask

  task automatic check_direct(input string name, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, got, want);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk_cnt++;
      if (pred_hit === e.hit && pred_taken === e.taken && pred_target === e.target &&
          int'(pred_way) == e.way && busy === e.busy) begin
        pass_cnt++;
        $display("tx %0d pc=%h hit=%b taken=%b target=%h way=%0d busy=%b",
                 e.id, e.pc, pred_hit, pred_taken, pred_target, pred_way, busy);
      end else begin
        $display("FAIL lookup tx %0d pc=%h: got hit=%b taken=%b target=%h way=%0d busy=%b, expected hit=%b taken=%b target=%h way=%0d busy=%b",
                 e.id, e.pc, pred_hit, pred_taken, pred_target, pred_way, busy,
                 e.hit, e.taken, e.target, e.way, e.busy);
      end
    end
  end

  function automatic logic [31:0] rand_pc();
    return ((urand_tag() * SETS) + $urandom_range(0, SETS - 1)) << IDX;
  endfunction

  function automatic int unsigned urand_tag();
    return $urandom_range(0, 3);
  endfunction

  initial begin
    rst_n = 1'b0; pc_current = 32'h100; upd_valid = 0; upd_pc = 0;
    upd_target = 0; upd_taken = 0; flush_req = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_direct("reset_busy", {31'b0, busy}, 32'h0);
    check_direct("reset_pred_hit", {31'b0, pred_hit}, 32'h0);
    check_direct("reset_pred_target", pred_target, 32'h0);
    check_direct("reset_pred_way", {31'b0, pred_way}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    look(32'h100);
    upd(32'h100, 32'h200, 1'b1);
    look(32'h100);
    upd(32'h100, 32'h999, 1'b0);
    upd(32'h100, 32'h999, 1'b0);
    look(32'h100);
    upd(32'h120, 32'h220, 1'b1);
    upd(32'h140, 32'h240, 1'b1);
    look(32'h100);
    look(32'h120);
    look(32'h140);
    upd(32'h300, 32'h400, 1'b0);
    look(32'h300);
    repeat (4) upd(32'h120, 32'h220, 1'b1);
    upd(32'h120, 32'h220, 1'b0);
    look(32'h120);

    cycle(32'h120, 1'b1, 32'h500, 32'h600, 1'b1, 1'b1);
    for (int i = 0; i < SETS; i++) cycle(32'h120, 1'b1, 32'h500, 32'h600, 1'b1, i[0]);
    look(32'h120);
    look(32'h140);
    look(32'h500);

    upd(32'h180, 32'h280, 1'b1);
    look(32'h180);
    cycle(32'h180, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    look(32'h180);
    look(32'h180);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_direct("midflush_reset_busy", {31'b0, busy}, 32'h0);
    check_direct("midflush_reset_hit", {31'b0, pred_hit}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    look(32'h180);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] p;
      p = rand_pc();
      cycle(rand_pc(), ($urandom_range(0, 9) < 7), p, $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
